// File: rtl/axis_pkt_checker.sv
// axis_pkt_checker: AXI4-Stream sink that checks incrementing-word packets; optional tready gaps via CHK_BACKPRESSURE_EN
module axis_pkt_checker #(
  parameter int          PKT_LEN = 16,
  parameter logic [31:0] SEED    = 32'h0000_0000,
  parameter int          CNT_W   = 16
) (
  input  logic             axis_aclk,
  input  logic             axis_aresetn,
  input  logic             start_read,
  input  logic             clear,
  input  logic             axis_tvalid,
  output logic             axis_tready,
  input  logic [31:0]      axis_tdata,
  input  logic [3:0]       axis_tkeep,
  input  logic             axis_tlast,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             data_err,
  output logic             len_err,
  output logic             busy
);
  typedef enum logic {IDLE, RECV} state_t;
  localparam logic [15:0] LAST = 16'(PKT_LEN - 1);
  state_t           state, state_nxt;
  logic [1:0]       rst_sync;
  logic             rst_n;
  logic [31:0]      expected;
  logic [15:0]      beat;
  logic             pkt_bad, late_seen;
  logic             acc, d_bad, early, late, l_bad, pkt_ok;
  logic [CNT_W:0]   err_sum;
  logic [CNT_W-1:0] err_nxt, pkt_nxt;
  assign rst_n = rst_sync[1];
  // reset asserts asynchronously, releases two clocks after axis_aresetn rises
  always_ff @(posedge axis_aclk or negedge axis_aresetn)
    if (!axis_aresetn) rst_sync <= 2'b00;
    else rst_sync <= {rst_sync[0], 1'b1};
`ifdef CHK_BACKPRESSURE_EN
  logic [15:0] lfsr;
  // free-running Galois LFSR (taps 16,14,13,11) used to punch gaps in tready
  always_ff @(posedge axis_aclk or negedge rst_n)
    if (!rst_n) lfsr <= 16'hACE1;
    else lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign axis_tready = (state == RECV) && (lfsr[1:0] != 2'b00);
`else
  assign axis_tready = (state == RECV);
`endif
  assign busy = (state == RECV);
  assign acc  = axis_tvalid && axis_tready;
  // beat classification and saturating next values for the counters
  always_comb begin
    d_bad   = (axis_tdata != expected) || (axis_tkeep != 4'hF);
    early   = axis_tlast && (beat < LAST);
    late    = !axis_tlast && (beat == LAST) && !late_seen;
    l_bad   = early || late;
    pkt_ok  = !(pkt_bad || d_bad || l_bad);
    err_sum = {1'b0, err_cnt} + {{CNT_W{1'b0}}, d_bad} + {{CNT_W{1'b0}}, l_bad};
    err_nxt = err_sum[CNT_W] ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
    pkt_nxt = (&pkt_cnt) ? pkt_cnt : pkt_cnt + 1'b1;
  end
  // state register
  always_ff @(posedge axis_aclk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // leave RECV only at a packet boundary once start_read has dropped
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE) ? (start_read ? RECV : IDLE)
                                : ((acc && axis_tlast && !start_read) ? IDLE : RECV);
  end
  // per-beat checking, counters and sticky flags; clear overrides an accepted beat
  always_ff @(posedge axis_aclk or negedge rst_n)
    if (!rst_n) begin
      expected  <= SEED;
      beat      <= 16'd0;
      pkt_bad   <= 1'b0;
      late_seen <= 1'b0;
      pkt_cnt   <= '0;
      err_cnt   <= '0;
      data_err  <= 1'b0;
      len_err   <= 1'b0;
    end else if (clear) begin
      expected  <= SEED;
      beat      <= 16'd0;
      pkt_bad   <= 1'b0;
      late_seen <= 1'b0;
      pkt_cnt   <= '0;
      err_cnt   <= '0;
      data_err  <= 1'b0;
      len_err   <= 1'b0;
    end else if (acc) begin
      expected  <= axis_tdata + 32'd1;
      beat      <= axis_tlast ? 16'd0 : ((beat == LAST) ? beat : beat + 16'd1);
      pkt_bad   <= axis_tlast ? 1'b0 : (pkt_bad || d_bad || l_bad);
      late_seen <= axis_tlast ? 1'b0 : (late_seen || late);
      pkt_cnt   <= (axis_tlast && pkt_ok) ? pkt_nxt : pkt_cnt;
      err_cnt   <= err_nxt;
      data_err  <= data_err || d_bad;
      len_err   <= len_err || l_bad;
    end
endmodule

// File: tb/tb_axis_pkt_checker.sv
// tb_axis_pkt_checker: directed self-checking bench for axis_pkt_checker
module tb_axis_pkt_checker;
  logic        clk = 0, rst_n = 1, start_read = 0, clear = 0;
  logic        tvalid = 0, tlast = 0, tready;
  logic [31:0] tdata = 0;
  logic [3:0]  tkeep = 4'hF;
  logic [2:0]  pkt_cnt, err_cnt;
  logic        data_err, len_err, busy;
  int          tests = 0, fails = 0, stalls = 0;
  axis_pkt_checker #(.PKT_LEN(16), .SEED(32'h0), .CNT_W(3)) dut (
    .axis_aclk(clk), .axis_aresetn(rst_n), .start_read(start_read), .clear(clear),
    .axis_tvalid(tvalid), .axis_tready(tready), .axis_tdata(tdata), .axis_tkeep(tkeep),
    .axis_tlast(tlast), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .data_err(data_err),
    .len_err(len_err), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(logic [31:0] d, logic last = 0, logic [3:0] k = 4'hF, logic clr = 0);
    int w = 0;
    tvalid = 1; tdata = d; tlast = last; tkeep = k;
    while (!tready && w < 50) begin
      step();
      w++;
      stalls++;
    end
    if (!tready) check("accept_timeout", 32'd0, 32'd1);
    clear = clr;
    step();
    clear = 0; tvalid = 0; tlast = 0; tkeep = 4'hF;
  endtask
  task automatic pkt(logic [31:0] base);
    for (int i = 0; i < 16; i++) send(base + i, i == 15);
  endtask
  task automatic pulse_clear();
    clear = 1;
    step();
    clear = 0;
  endtask
  task automatic expect_cnt(string tag, int p, int e, logic de, logic le);
    step(2);
    check({tag, "_pkt"}, pkt_cnt, p);
    check({tag, "_err"}, err_cnt, e);
    check({tag, "_data_err"}, data_err, de);
    check({tag, "_len_err"}, len_err, le);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    #1 rst_n = 0;
    step(2);
    check("rst_tready", tready, 0);
    check("rst_busy", busy, 0);
    expect_cnt("rst", 0, 0, 0, 0);
    rst_n = 1;
    step(3);
    check("idle_tready", tready, 0);
    start_read = 1;
    step();
    check("recv_busy", busy, 1);
`ifndef CHK_BACKPRESSURE_EN
    check("recv_tready", tready, 1);
`endif
    for (int i = 0; i < 48; i++) send(i, i % 16 == 15);
    expect_cnt("three_pkts", 3, 0, 0, 0);
    for (int i = 0; i < 16; i++) send(i == 5 ? 32'hDEAD_BEEF : 48 + i, i == 15);
    expect_cnt("bad_data", 3, 2, 1, 0);
    pkt(64);
    expect_cnt("after_bad", 4, 2, 1, 0);
    pulse_clear();
    expect_cnt("clear1", 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) send(i, i == 9);
    expect_cnt("early", 0, 1, 0, 1);
    pkt(10);
    expect_cnt("after_early", 1, 1, 0, 1);
    stalls = 0;
    for (int i = 0; i < 20; i++) send(26 + i, i == 19);
`ifndef CHK_BACKPRESSURE_EN
    check("late_no_stall", stalls, 0);
`endif
    expect_cnt("late", 1, 2, 0, 1);
    pkt(46);
    expect_cnt("after_late", 2, 2, 0, 1);
    pulse_clear();
    for (int i = 0; i < 16; i++) begin
      send(i, i == 15);
      if (i == 7) start_read = 0;
    end
    check("stop_tready", tready, 0);
    check("stop_busy", busy, 0);
    expect_cnt("stop", 1, 0, 0, 0);
    check("stop_idle_tready", tready, 0);
    start_read = 1;
    for (int i = 16; i < 20; i++) send(i);
    tvalid = 1; tdata = 20;
    #2 rst_n = 0;
    #1;
    check("arst_tready", tready, 0);
    check("arst_busy", busy, 0);
    check("arst_pkt", pkt_cnt, 0);
    tvalid = 0;
    step(2);
    rst_n = 1;
    step(3);
    pkt(0);
    expect_cnt("post_rst", 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) send(16 + i, i == 15, i == 3 ? 4'h7 : 4'hF);
    expect_cnt("bad_keep", 1, 1, 1, 0);
    pulse_clear();
    expect_cnt("clear2", 0, 0, 0, 0);
    pkt(0);
    expect_cnt("seed_pkt", 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) send(16 + i);
    send(99, 1);
    expect_cnt("double_err", 1, 2, 1, 1);
    send(100);
    send(101);
    send(5, 0, 4'h0, 1);
    expect_cnt("clear_beat", 0, 0, 0, 0);
    pkt(0);
    expect_cnt("after_clear_beat", 1, 0, 0, 0);
    pulse_clear();
    for (int i = 0; i < 7; i++) send(i, i == 6, 4'h0);
    expect_cnt("err_sat", 0, 7, 1, 1);
    pulse_clear();
    for (int p = 0; p < 8; p++) pkt(p * 16);
    expect_cnt("pkt_sat", 7, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axis_pkt_checker.md
Name: axis_pkt_checker

Overview:
- AXI4-Stream sink at the output end of the loopback path (data_gen -> axis_data_fifo -> here); consumes packets from the FIFO master port.
- Checks each beat against the generator's pattern: a running 32-bit incrementing word, tkeep all ones, tlast on the final beat of a fixed-length packet.
- Counts good packets and errors, and exposes sticky flags for VIO/ILA probing on hardware.

Parameters:
- PKT_LEN, 16: beats per packet; legal range 2..65535.
- SEED, 32'h0000_0000: expected tdata of the first beat after reset or clear.
- CNT_W, 16: width of pkt_cnt and err_cnt.

Ports:
- axis_aclk  in  1  clock; all logic is on the rising edge.
- axis_aresetn  in  1  asynchronous active-low reset; assertion is asynchronous, deassertion is synchronised inside the block.
- start_read  in  1  level enable from the VIO; high allows packet acceptance.
- clear  in  1  synchronous pulse; zeroes counters, flags and expected data (back to SEED).
- axis_tvalid  in  1  AXIS valid.
- axis_tready  out  1  AXIS ready.
- axis_tdata  in  32  AXIS data.
- axis_tkeep  in  4  AXIS byte enables.
- axis_tlast  in  1  AXIS end of packet.
- pkt_cnt  out  CNT_W  count of packets that completed with no error; saturates at all ones.
- err_cnt  out  CNT_W  count of erroneous beats plus length errors; saturates at all ones.
- data_err  out  1  sticky; set on a tdata or tkeep mismatch.
- len_err  out  1  sticky; set when tlast is early or late.
- busy  out  1  high while in the RECV state.

Behaviour:
- Reset values: axis_tready=0, pkt_cnt=0, err_cnt=0, data_err=0, len_err=0, busy=0, expected=SEED, beat=0, state=IDLE.
- A beat is accepted only when tvalid && tready are both high on a rising edge. No combinational path from tvalid to tready; tready is registered.
- State IDLE:
  - tready=0.
  - start_read sampled high -> RECV on the next cycle; tready rises on that cycle.
- State RECV:
  - tready=1, busy=1.
  - On each accepted beat:
    - Compare tdata with expected and tkeep with 4'hF. On a mismatch: err_cnt+1 (one increment per bad beat, even if both fields are wrong), data_err set, packet marked bad.
    - expected <= tdata+1 on every beat, mismatched or not (resynchronises; wraps 32'hFFFF_FFFF -> 0).
  - Beat counter: 16 bits, counts 0..PKT_LEN-1, then saturates at PKT_LEN-1.
  - tlast with beat < PKT_LEN-1: early; len_err set, err_cnt+1, packet bad.
  - Beat PKT_LEN-1 accepted without tlast: late; len_err set, err_cnt+1, packet bad. The block stays in RECV, accepts until tlast, and flags no further length errors for that packet.
  - On the tlast beat:
    - pkt_cnt+1 if the packet is not bad.
    - beat<=0; packet-bad flag cleared.
    - If start_read is low -> IDLE (tready=0 from the next cycle); else stay in RECV.
  - start_read falling mid-packet: the current packet completes to tlast; no truncation.
- Latency: counters and flags update on the edge after the accepting edge (one-cycle registered).
- Simultaneous data and length error on one beat: err_cnt+2 (the sum saturates); both flags set.
- clear together with an accepted beat: clear wins; that beat's contribution is dropped, beat<=0, expected<=SEED. State and tready are not affected.
- Counter saturation: at all ones the counter holds; no wrap.
- Reset mid-packet: everything returns to reset values immediately; the partial packet is discarded.

Optional Feature:
- Macro CHK_BACKPRESSURE_EN.
- Defined:
  - A 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1; advances every cycle) gates tready in RECV. tready = RECV && lfsr[1:0]!=2'b00, giving about 75% duty.
  - This stresses the FIFO's full/hold behaviour. Checking behaviour is unchanged.
- Undefined: tready is constantly 1 in RECV; no LFSR logic is synthesised.

Test Plan:
- Reset, start_read=1, three packets of 16 beats with data 0..47, tkeep=F, tlast on beats 15/31/47 -> pkt_cnt=3, err_cnt=0, data_err=0, len_err=0.
- Packet with beat 5 data 32'hDEAD_BEEF instead of 5, rest correct -> err_cnt=2 (beat 5 and resync miss at beat 6 expecting DEAD_BEF0), data_err=1, pkt_cnt unchanged; the next clean packet starting at 16 increments pkt_cnt.
- tlast on beat 9 of 16 -> len_err=1, err_cnt=1, pkt_cnt=0; the following 16-beat packet counts normally.
- 20 beats with tlast only on beat 19 -> one length error, err_cnt=1, tready stays high until beat 19 is accepted.
- Drop start_read at beat 7 -> beats 8..15 are still accepted; tready=0 the cycle after tlast; busy=0.
- Assert axis_aresetn low during beat 4, then release; pulse clear after a bad packet -> all counters and flags are 0, and the next packet starting at SEED passes. With CHK_BACKPRESSURE_EN, tready shows gaps and pkt_cnt still matches.
